alu_seq: RTL and testbench

Parametrised, handshaked successor to the datapath ALU. It accepts one operation per transaction over a valid/ready interface and returns a registered result plus status flags. Single-cycle ops complete in one clock; MUL runs as an iterative shift-add over WIDTH cycles. The block sits between the decode stage and register writeback, and the stall logic uses `busy` and the handshakes.

---
 rtl/alu_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
// Single-cycle ops finish in one clock; MUL is an iterative shift-add
// over WIDTH cycles, during which busy is high.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. out_valid
// never drops and result/flags never change until that transfer happens.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_CLR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_SHL = 4'b1110;
    localparam logic [3:0] OP_SHR = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic is_mul;

    // multiplier datapath
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [SHW-1:0]     cnt;

    // single-cycle ALU intermediates
    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   sub_res;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign dbg_state = state;

    // Shifts are done one bit wider so the last bit shifted out lands in the
    // extra position; with a zero amount that position is 0 by construction.
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_res = a - b;
    assign shamt   = b[SHW-1:0];
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = is_mul ? S_MUL : S_DONE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
        out_valid = (state == S_DONE);
        busy      = (state == S_MUL);
    end

    // Single-cycle ALU result and flag candidates
    always_comb begin
        alu_res   = a;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_res;
                alu_carry = (a < b);
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOT: alu_res = ~a;
            OP_CLR: alu_res = '0;
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            default: alu_res = a;
        endcase
    end

    // Datapath registers: capture on accept, iterate in MUL, publish results
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= SHW'(WIDTH - 1);
            end else begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                neg    <= alu_res[WIDTH-1];
                carry  <= alu_carry;
                ovf    <= alu_ovf;
            end
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - SHW'(1);
            if (cnt == '0) begin
                result <= acc_next[WIDTH-1:0];
                zero   <= (acc_next[WIDTH-1:0] == '0);
                neg    <= acc_next[WIDTH-1];
                carry  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                ovf    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=16).
// Outputs are sampled 1ns after the rising edge; inputs change there too.
// The packed observation word is {out_valid, result, zero, neg, carry, ovf}.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         busy;
    logic [1:0]   dbg_state;

    logic [W+4:0] obs;

    int errors;
    int checks;

    assign obs = {out_valid, result, zero, neg, carry, ovf};

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and global watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge, then scramble the operands
    // so that any late sampling of op/a/b shows up as a wrong result.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        tick();
        in_valid = 1'b0;
        op = 4'($urandom_range(0, 15));
        a  = W'($urandom_range(0, 65535));
        b  = W'($urandom_range(0, 65535));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 4'd0;
        a = '0;
        b = '0;
        tick();
        tick();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
        end
        checks++;
        if ({busy, dbg_state, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got busy=%b state=%0d in_ready=%b expected 0,0,0", busy, dbg_state, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        send(4'b0000, 16'h7FFF, 16'h0001);
        checks++;
        if (obs !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_7fff_1: got %h expected %h", obs, {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        drain();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid got %b expected 0", out_valid);
        end
        send(4'b0000, 16'hFFFF, 16'h0001);
        checks++;
        if (obs !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ffff_1: got %h expected %h", obs, {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        drain();
    endtask

    task automatic test_sub();
        send(4'b0111, 16'h0003, 16'h0005);
        checks++;
        if (obs !== {1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_3_5: got %h expected %h", obs, {1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        drain();
        send(4'b0111, 16'h0005, 16'h0005);
        checks++;
        if (obs !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_5_5: got %h expected %h", obs, {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        drain();
        send(4'b0111, 16'h8000, 16'h0001);
        checks++;
        if (obs !== {1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_8000_1: got %h expected %h", obs, {1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        drain();
    endtask

    task automatic test_mul();
        logic [W-1:0] t_a[3];
        logic [W-1:0] t_b[3];
        logic [W+4:0] t_exp[3];
        int cycles;
        int busy_cnt;
        t_a   = '{16'h0123, 16'h00FF, 16'h1234};
        t_b   = '{16'h0100, 16'h00FF, 16'h0000};
        t_exp = '{{1'b1, 16'h2300, 1'b0, 1'b0, 1'b1, 1'b0},
                  {1'b1, 16'hFE01, 1'b0, 1'b1, 1'b0, 1'b0},
                  {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            send(4'b1101, t_a[i], t_b[i]);
            cycles = 1;
            busy_cnt = busy ? 1 : 0;
            while (!out_valid && cycles < 40) begin
                tick();
                cycles++;
                if (busy) busy_cnt++;
            end
            checks++;
            if (cycles !== W + 1) begin
                errors++;
                $display("FAIL mul%0d_latency: got %0d cycles expected %0d", i, cycles, W + 1);
            end
            checks++;
            if (busy_cnt !== W) begin
                errors++;
                $display("FAIL mul%0d_busy_cycles: got %0d expected %0d", i, busy_cnt, W);
            end
            checks++;
            if (obs !== t_exp[i]) begin
                errors++;
                $display("FAIL mul%0d_result: got %h expected %h", i, obs, t_exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        send(4'b0000, 16'h0001, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            // An OR request is presented during the stall; it must not be taken.
            if (i >= 2) begin
                in_valid = 1'b1;
                op = 4'b1001;
                a = 16'hF0F0;
                b = 16'h0F0F;
            end
            #1;
            checks++;
            if ({obs, in_ready} !== {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got obs=%h in_ready=%b expected obs=%h in_ready=0",
                         i, obs, in_ready, {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0});
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (obs !== {1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_then_or: got %h expected %h", obs, {1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0]   t_op[5];
        logic [W-1:0] t_a[5];
        logic [W-1:0] t_b[5];
        logic [W+4:0] t_exp[5];
        t_op  = '{4'b1000, 4'b1010, 4'b0100, 4'b0001, 4'b0010};
        t_a   = '{16'hF0F0, 16'h00FF, 16'h1234, 16'h1234, 16'h8000};
        t_b   = '{16'hFF00, 16'h5555, 16'hFFFF, 16'h0000, 16'h0001};
        t_exp = '{{1'b1, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0},
                  {1'b1, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0},
                  {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
                  {1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0},
                  {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = t_op[i];
            a = t_a[i];
            b = t_b[i];
            tick();
            checks++;
            if (obs !== t_exp[i]) begin
                errors++;
                $display("FAIL b2b%0d_op%b: got %h expected %h", i, t_op[i], obs, t_exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, dbg_state} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b state=%0d expected 0,0", out_valid, dbg_state);
        end
    endtask

    task automatic test_shift();
        logic [3:0]   t_op[5];
        logic [W-1:0] t_a[5];
        logic [W-1:0] t_b[5];
        logic [W+4:0] t_exp[5];
        t_op  = '{4'b1110, 4'b1111, 4'b1111, 4'b1110, 4'b1111};
        t_a   = '{16'h8001, 16'h0001, 16'h0003, 16'h1234, 16'h8000};
        t_b   = '{16'h0001, 16'h0000, 16'h0001, 16'h0014, 16'h000F};
        t_exp = '{{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0},
                  {1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0},
                  {1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0},
                  {1'b1, 16'h2340, 1'b0, 1'b0, 1'b1, 1'b0},
                  {1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (obs !== t_exp[i]) begin
                errors++;
                $display("FAIL shift%0d_op%b: got %h expected %h", i, t_op[i], obs, t_exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen_valid;
        send(4'b1101, 16'h00FF, 16'h00FF);
        repeat (7) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, dbg_state, out_valid, in_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_state: got busy=%b state=%0d out_valid=%b in_ready=%b expected all 0",
                     busy, dbg_state, out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release_ready: got %b expected 1", in_ready);
        end
        seen_valid = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen_valid !== 0) begin
            errors++;
            $display("FAIL abort_no_output: out_valid seen %0d cycles expected 0", seen_valid);
        end
        send(4'b0000, 16'h0002, 16'h0002);
        checks++;
        if (obs !== {1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_then_add: got %h expected %h", obs, {1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_shift();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
